// File: rtl/count_pkg.sv
// Shared definitions for the count_sweep_ctrl slice.
// Contents:
//   - default widths for counter value, sweep count and dwell length
//   - state encodings ST_IDLE..ST_DONE and the matching state_e enum
package count_pkg;

  localparam int CNT_W_DEF   = 4;
  localparam int CYC_W_DEF   = 8;
  localparam int DWELL_W_DEF = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HOME     = 3'd1;
  localparam logic [2:0] ST_UP       = 3'd2;
  localparam logic [2:0] ST_DWELL_HI = 3'd3;
  localparam logic [2:0] ST_DOWN     = 3'd4;
  localparam logic [2:0] ST_DWELL_LO = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_HOME     = ST_HOME,
    S_UP       = ST_UP,
    S_DWELL_HI = ST_DWELL_HI,
    S_DOWN     = ST_DOWN,
    S_DWELL_LO = ST_DWELL_LO,
    S_DONE     = ST_DONE
  } state_e;

endpackage

// File: rtl/countUpDown.sv
// 4-bit (parameterisable) up/down counter driven by the sweep sequencer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (count -> 0)
//   enable       count this cycle
//   countUpDown  direction: 1 = up, 0 = down (wraps modulo 2^W)
//   count        registered count value
module countUpDown #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         countUpDown,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= countUpDown ? count_q + W'(1) : count_q - W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sweep_dwell_timer.sv
// Down-counter that times the hold at each sweep bound.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       load load_val_i (takes priority over dec_i)
//   load_val_i   value to load
//   dec_i        decrement by one, stopping at zero
//   zero_o       timer value is zero
module sweep_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] tmr_q;
  logic [W-1:0] tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (load_i) begin
      tmr_d = load_val_i;
    end else if (dec_i && (tmr_q != '0)) begin
      tmr_d = tmr_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign zero_o = (tmr_q == '0);

endmodule

// File: rtl/count_sweep_ctrl.sv
// Sweep sequencer for a countUpDown counter: homes the counter to LO, then runs
// triangle sweeps LO->HI (dwell) HI->LO (dwell) for cycles_cfg sweeps (0 = until
// abort) and pulses done. The counter's count is fed back so that motion stops
// exactly on each bound.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   start                     1-cycle pulse, accepted only in IDLE
//   abort                     level, ends the run via DONE
//   lo_cfg/hi_cfg             sweep bounds
//   cycles_cfg/dwell_cfg      sweep count (0 = continuous), dwell cycles
//   cnt_value                 counter feedback
//   cnt_enable/cnt_up         counter controls
//   busy/done/err/sweep_cnt   status
//   dbg_state                 current FSM state encoding
//
// Handshake: start is a single-cycle request sampled on the rising edge; it is
// accepted only when busy is low and abort is low, and is dropped (never queued)
// otherwise. done is a single-cycle completion strobe; busy is high from the
// cycle after an accepted start up to and including the done cycle.
module count_sweep_ctrl
  import count_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int CYC_W   = CYC_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   lo_cfg,
  input  logic [CNT_W-1:0]   hi_cfg,
  input  logic [CYC_W-1:0]   cycles_cfg,
  input  logic [DWELL_W-1:0] dwell_cfg,
  input  logic [CNT_W-1:0]   cnt_value,
  output logic               cnt_enable,
  output logic               cnt_up,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CYC_W-1:0]   sweep_cnt,
  output logic [2:0]         dbg_state
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   hi_q, hi_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CYC_W-1:0]   sweep_q, sweep_d;
  logic               err_q, err_d;
  logic               up_q, up_d;

  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_zero;
  logic [DWELL_W-1:0] tmr_load_val;
  logic [CYC_W-1:0]   sweep_inc;

  // The dwell state itself occupies one cycle, so load dwell-1; a zero dwell
  // still spends that single cycle in the dwell state.
  assign tmr_load_val = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

  // Continuous runs keep counting but never wrap back to zero.
  assign sweep_inc = (&sweep_q) ? sweep_q : sweep_q + CYC_W'(1);

  sweep_dwell_timer #(
    .W (DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    cyc_d      = cyc_q;
    dwell_d    = dwell_q;
    sweep_d    = sweep_q;
    err_d      = err_q;
    // Direction holds its last value whenever the counter is not moving.
    up_d       = up_q;
    cnt_enable = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (lo_cfg > hi_cfg) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            lo_d    = lo_cfg;
            hi_d    = hi_cfg;
            cyc_d   = cycles_cfg;
            dwell_d = dwell_cfg;
            sweep_d = '0;
            err_d   = 1'b0;
            state_d = S_HOME;
          end
        end
      end

      S_HOME: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (cnt_value == lo_q) begin
          state_d = S_UP;
        end else begin
          // Move straight toward LO; never rely on wrap-around.
          cnt_enable = 1'b1;
          up_d       = (cnt_value < lo_q);
        end
      end

      S_UP: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (cnt_value == hi_q) begin
          tmr_load = 1'b1;
          state_d  = S_DWELL_HI;
        end else begin
          cnt_enable = 1'b1;
          up_d       = 1'b1;
        end
      end

      S_DWELL_HI: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (tmr_zero) begin
          state_d = S_DOWN;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      S_DOWN: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (cnt_value == lo_q) begin
          tmr_load = 1'b1;
          state_d  = S_DWELL_LO;
        end else begin
          cnt_enable = 1'b1;
          up_d       = 1'b0;
        end
      end

      S_DWELL_LO: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (tmr_zero) begin
          sweep_d = sweep_inc;
          if ((cyc_q != '0) && (sweep_inc == cyc_q)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_UP;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      cyc_q   <= '0;
      dwell_q <= '0;
      sweep_q <= '0;
      err_q   <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cyc_q   <= cyc_d;
      dwell_q <= dwell_d;
      sweep_q <= sweep_d;
      err_q   <= err_d;
      up_q    <= up_d;
    end
  end

  assign cnt_up    = up_d;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign sweep_cnt = sweep_q;
  assign dbg_state = state_q;

endmodule
